// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control symbols, default 1080p60 timing, the
// 10-bit symbol type and small bit-counting helpers.
package tmds_pkg;

  typedef logic [9:0] sym10_t;

  // Control-period symbols indexed by {C1,C0}
  localparam sym10_t CTRL_00 = 10'b1101010100;
  localparam sym10_t CTRL_01 = 10'b0010101011;
  localparam sym10_t CTRL_10 = 10'b0101010100;
  localparam sym10_t CTRL_11 = 10'b1010101011;

  // Default 1080p60 timing at 148.5 MHz
  localparam int DEF_H_ACTIVE = 1920;
  localparam int DEF_H_FP     = 88;
  localparam int DEF_H_SYNC   = 44;
  localparam int DEF_H_BP     = 148;
  localparam int DEF_V_ACTIVE = 1080;
  localparam int DEF_V_FP     = 4;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 36;

  function automatic sym10_t ctrl_symbol(input logic [1:0] c);
    sym10_t s;
    case (c)
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_video_encoder_channel.sv
// One TMDS lane: stage 1 transition minimisation, stage 2 DC balancing with
// a running disparity counter, or a control symbol during blanking.
module tmds_channel_encoder
  import tmds_pkg::*;
(
  input  logic       txoutclk_internal,
  input  logic       reset,
  input  logic       de,
  input  logic [1:0] c,
  input  logic [7:0] d,
  output sym10_t     q
);

  logic [8:0]        q_m_p1;
  logic              de_p1;
  logic [1:0]        c_p1;
  logic signed [4:0] cnt_p2;

  logic [3:0]        n1_qm;
  logic signed [5:0] diff;
  logic signed [5:0] cnt_ext;
  logic signed [5:0] cnt_next;
  sym10_t            q_next;

  // XOR chain, or XNOR chain when the byte is transition-heavy; bit 8 flags XOR.
  function automatic logic [8:0] minimise(input logic [7:0] din);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] qm;
    n1       = ones8(din);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !din[0]);
    qm       = '0;
    qm[0]    = din[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ din[i]) : (qm[i-1] ^ din[i]);
    qm[8]    = ~use_xnor;
    return qm;
  endfunction

  // Stage 1: register the minimised word with its de/control tags
  always_ff @(posedge txoutclk_internal) begin
    if (reset) begin
      q_m_p1 <= '0;
      de_p1  <= 1'b0;
      c_p1   <= 2'b00;
    end else begin
      q_m_p1 <= minimise(d);
      de_p1  <= de;
      c_p1   <= c;
    end
  end

  // Stage 2 decision: pick the inversion that steers disparity toward zero
  always_comb begin
    n1_qm    = ones8(q_m_p1[7:0]);
    diff     = $signed({1'b0, n1_qm, 1'b0}) - 6'sd8;  // n1 - n0
    cnt_ext  = {cnt_p2[4], cnt_p2};
    q_next   = ctrl_symbol(c_p1);
    cnt_next = 6'sd0;
    if (de_p1) begin
      if ((cnt_p2 == 5'sd0) || (diff == 6'sd0)) begin
        q_next   = {~q_m_p1[8], q_m_p1[8],
                    q_m_p1[8] ? q_m_p1[7:0] : ~q_m_p1[7:0]};
        cnt_next = q_m_p1[8] ? (cnt_ext + diff) : (cnt_ext - diff);
      end else if (((cnt_p2 > 5'sd0) && (diff > 6'sd0)) ||
                   ((cnt_p2 < 5'sd0) && (diff < 6'sd0))) begin
        q_next   = {1'b1, q_m_p1[8], ~q_m_p1[7:0]};
        cnt_next = cnt_ext + (q_m_p1[8] ? 6'sd2 : 6'sd0) - diff;
      end else begin
        q_next   = {1'b0, q_m_p1[8], q_m_p1[7:0]};
        cnt_next = cnt_ext - (q_m_p1[8] ? 6'sd0 : 6'sd2) + diff;
      end
    end
  end

  // Stage 2: output symbol and disparity; blanking forces disparity to zero
  always_ff @(posedge txoutclk_internal) begin
    if (reset) begin
      q      <= CTRL_00;
      cnt_p2 <= 5'sd0;
    end else begin
      q      <= q_next;
      cnt_p2 <= cnt_next[4:0];
    end
  end

endmodule

// File: rtl/tmds_video_encoder.sv
// Video timing generator plus three TMDS lane encoders (r=ch2, g=ch1, b=ch0).
// Optional macro TMDS_TEST_PATTERN_EN adds eight vertical colour bars selected
// by test_pattern_sel; without it test_pattern_sel is ignored.
module tmds_video_encoder
  import tmds_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic       txoutclk_internal,
  input  logic       reset,
  input  logic [7:0] pixel_r,
  input  logic [7:0] pixel_g,
  input  logic [7:0] pixel_b,
  input  logic       test_pattern_sel,
  output logic       pix_req,
  output logic       frame_start,
  output sym10_t     r,
  output sym10_t     g,
  output sym10_t     b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        de_p0;
  logic        hsync_p0;
  logic        vsync_p0;
  logic [1:0]  c_blu_p0;
  logic [7:0]  red_p0;
  logic [7:0]  grn_p0;
  logic [7:0]  blu_p0;

  // Stage 0: raster counters, line then frame wrap
  always_ff @(posedge txoutclk_internal) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == 12'(H_TOTAL - 1)) begin
      hcount <= '0;
      vcount <= (vcount == 12'(V_TOTAL - 1)) ? 12'd0 : vcount + 12'd1;
    end else begin
      hcount <= hcount + 12'd1;
    end
  end

  // Region decode; sync lines carry the physical polarity, then the control
  // bits are normalised back to "1 = asserted" for the blue lane.
  always_comb begin
    de_p0    = (hcount < 12'(H_ACTIVE)) && (vcount < 12'(V_ACTIVE));
    hsync_p0 = ((hcount >= 12'(H_ACTIVE + H_FP)) &&
                (hcount <  12'(H_ACTIVE + H_FP + H_SYNC))) ? SYNC_POL : ~SYNC_POL;
    vsync_p0 = ((vcount >= 12'(V_ACTIVE + V_FP)) &&
                (vcount <  12'(V_ACTIVE + V_FP + V_SYNC))) ? SYNC_POL : ~SYNC_POL;
    c_blu_p0 = {vsync_p0 == SYNC_POL, hsync_p0 == SYNC_POL};
    pix_req     = de_p0 && !reset;
    frame_start = (hcount == 12'd0) && (vcount == 12'd0) && !reset;
  end

`ifdef TMDS_TEST_PATTERN_EN
  logic [2:0] bar;

  // Colour bars: white, yellow, cyan, green, magenta, red, blue, black
  always_comb begin
    bar = 3'(hcount / 12'(H_ACTIVE / 8));
    if (test_pattern_sel) begin
      red_p0 = {8{~bar[1]}};
      grn_p0 = {8{~bar[2]}};
      blu_p0 = {8{~bar[0]}};
    end else begin
      red_p0 = pixel_r;
      grn_p0 = pixel_g;
      blu_p0 = pixel_b;
    end
  end
`else
  logic unused_sel;

  // Pixel inputs pass straight through; the pattern select has no effect
  always_comb begin
    unused_sel = test_pattern_sel;
    red_p0     = pixel_r;
    grn_p0     = pixel_g;
    blu_p0     = pixel_b;
  end
`endif

  tmds_channel_encoder u_enc_r (
    .txoutclk_internal (txoutclk_internal),
    .reset             (reset),
    .de                (de_p0),
    .c                 (2'b00),
    .d                 (red_p0),
    .q                 (r)
  );

  tmds_channel_encoder u_enc_g (
    .txoutclk_internal (txoutclk_internal),
    .reset             (reset),
    .de                (de_p0),
    .c                 (2'b00),
    .d                 (grn_p0),
    .q                 (g)
  );

  tmds_channel_encoder u_enc_b (
    .txoutclk_internal (txoutclk_internal),
    .reset             (reset),
    .de                (de_p0),
    .c                 (c_blu_p0),
    .d                 (blu_p0),
    .q                 (b)
  );

endmodule
